// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding and the fetch-queue entry layout.
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fsm_e;

    localparam logic [63:0] IFU_PC_ENTRY = 64'h8000_0000;
    localparam int IFU_XLEN = 64;
    localparam int IFU_ILEN = 32;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [IFU_ILEN-1:0] inst;
        logic                fault;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: power-of-two synchronous FIFO between fetch and decode.
// Flush clears occupancy and both pointers in one cycle.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 97
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [W-1:0]             head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner, single-outstanding imem requester and fetch queue.
// IFU_MISALIGN_CHECK_EN turns misaligned redirect targets into fault entries.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] PC_ENTRY = XLEN'(IFU_PC_ENTRY),
    parameter int              QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex,
    input  logic [XLEN-1:0] ex_entry,
    input  logic            ex_ret,
    input  logic [XLEN-1:0] epc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [ILEN-1:0] rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_inst,
    output logic            id_fault
);

    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            fault;
    } ent_t;

    fsm_e            state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_req_q;
    logic [XLEN-1:0] target, redir_pc;
    logic            run_q, halt_q, fault_q, misalign;
    logic            redirect, hs, credit;
    logic            rsp_push, fault_push;
    logic            q_push, q_pop, q_full, q_empty;
    logic [CW-1:0]   q_count;
    ent_t            q_din, q_head;

    assign redirect = ex | ex_ret | br_taken;
    assign target   = ex ? ex_entry : (ex_ret ? epc : br_target);

`ifdef IFU_MISALIGN_CHECK_EN
    assign misalign = |target[1:0];
    assign redir_pc = target;
`else
    assign misalign = 1'b0;
    assign redir_pc = target & ~XLEN'(3);
`endif

    // No request is outstanding in REQ, so credit is queue space alone
    assign credit    = q_count < CW'(QDEPTH);
    assign req_valid = run_q & ~halt_q & (state_q == REQ) & credit;
    assign req_addr  = pc_q;
    assign hs        = req_valid & req_ready;

    assign rsp_push   = (state_q == WAIT) & rsp_valid & ~redirect;
    assign fault_push = fault_q & ~redirect;
    assign q_pop      = ~q_empty & id_ready & ~redirect;
    assign q_push     = (rsp_push | fault_push) & (~q_full | q_pop);

    always_comb begin
        q_din = '{pc: pc_req_q, inst: rsp_data, fault: 1'b0};
        if (fault_push) q_din = '{pc: pc_q, inst: '0, fault: 1'b1};
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            REQ: begin
                if (hs) state_d = redirect ? DRAIN : WAIT;
            end
            WAIT: begin
                if (rsp_valid)     state_d = REQ;
                else if (redirect) state_d = DRAIN;
            end
            DRAIN: begin
                if (rsp_valid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
        if (redirect) pc_d = redir_pc;
        else if (hs)  pc_d = pc_q + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= REQ;
            pc_q     <= PC_ENTRY;
            pc_req_q <= '0;
            run_q    <= 1'b0;
            halt_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            run_q   <= 1'b1;
            if (hs) pc_req_q <= pc_q;
            // Fault entry lands the cycle after the flush that clears the queue
            if (redirect) begin
                halt_q  <= misalign;
                fault_q <= misalign;
            end else begin
                fault_q <= 1'b0;
            end
        end
    end

    ifu_fetch_queue #(
        .DEPTH (QDEPTH),
        .W     ($bits(ent_t))
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect),
        .din   (q_din),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty),
        .head  (q_head)
    );

    assign id_valid = ~q_empty;
    assign id_pc    = q_empty ? '0 : q_head.pc;
    assign id_inst  = q_empty ? '0 : q_head.inst;
    assign id_fault = ~q_empty & q_head.fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed stimulus with a queue-based scoreboard on the id port.
// A small memory model answers requests after a programmable latency.
`timescale 1ns/1ps
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex = 1'b0, ex_ret = 1'b0, br_taken = 1'b0;
    logic [63:0] ex_entry = '0, epc = '0, br_target = '0;
    logic        req_ready = 1'b1;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        id_ready = 1'b1;
    logic        req_valid, id_valid, id_fault;
    logic [63:0] req_addr, id_pc;
    logic [31:0] id_inst;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          mem_lat = 1;
    logic        hs_flag = 1'b0;
    logic [63:0] hs_addr = '0;
    logic        outst = 1'b0, stale = 1'b0, deliv_prev = 1'b0;
    logic [63:0] outst_addr = '0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .ex        (ex),
        .ex_entry  (ex_entry),
        .ex_ret    (ex_ret),
        .epc       (epc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .id_fault  (id_fault)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(input string nm, input logic [63:0] a,
                            output int k);
        k = 0;
        while (!(req_valid && req_ready) && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no request seen, expected addr %h", nm, a);
        end else begin
            check(nm, req_addr, a);
        end
        tick();
    endtask

    task automatic wait_rsp(input string nm);
        int k = 0;
        while (!rsp_valid && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: memory response never arrived", nm);
        end
    endtask

    task automatic redir_br(input logic [63:0] t);
        br_taken  = 1'b1;
        br_target = t;
        tick();
        br_taken = 1'b0;
    endtask

    // Memory model: answers the request captured at the last negedge
    initial begin
        logic        pend;
        logic [63:0] pend_addr;
        int          wcnt;
        pend = 1'b0;
        pend_addr = '0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            rsp_valid = 1'b0;
            if (hs_flag) begin
                pend = 1'b1;
                pend_addr = hs_addr;
                wcnt = mem_lat - 1;
            end
            if (pend) begin
                if (wcnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic redir;
        exp_t e;
        redir = ex | ex_ret | br_taken;
        if (rst) begin
            exp_q.delete();
            outst = 1'b0;
            stale = 1'b0;
            deliv_prev = 1'b0;
            hs_flag = 1'b0;
        end else begin
            if (deliv_prev) check("id_latency", id_valid, 1);
            deliv_prev = 1'b0;
            if (id_valid && id_ready && !redir) begin
                if (exp_q.size() == 0) begin
                    check("id_spurious", id_pc, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("id_pc", id_pc, e.pc);
                    check("id_inst", id_inst, e.inst);
                    check("id_fault", id_fault, e.fault);
                end
            end
            if (redir) begin
                exp_q.delete();
                if (outst) stale = 1'b1;
`ifdef IFU_MISALIGN_CHECK_EN
                begin
                    logic [63:0] tgt;
                    tgt = ex ? ex_entry : (ex_ret ? epc : br_target);
                    if (tgt[1:0] != 2'b00)
                        exp_q.push_back('{pc: tgt, inst: 32'h0, fault: 1'b1});
                end
`endif
            end
            if (rsp_valid) begin
                if (outst && !stale && !redir) begin
                    exp_q.push_back('{pc: outst_addr,
                                      inst: mem_word(outst_addr),
                                      fault: 1'b0});
                    deliv_prev = 1'b1;
                end
                outst = 1'b0;
                stale = 1'b0;
            end
            if (req_valid && req_ready) begin
                outst = 1'b1;
                stale = redir;
                outst_addr = req_addr;
            end
            hs_flag = req_valid && req_ready;
            hs_addr = req_addr;
        end
    end

    initial begin
        int k;
        int n;
        repeat (3) tick();
        check("rst_req_valid", req_valid, 0);
        check("rst_req_addr", req_addr, 64'h8000_0000);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_id_inst", id_inst, 0);
        check("rst_id_fault", id_fault, 0);
        rst = 1'b0;
        check("rel_req_valid", req_valid, 0);

        wait_req("t1_a0", 64'h8000_0000, k);
        check("t1_first_lat", k, 1);
        wait_req("t1_a1", 64'h8000_0004, k);
        check("t1_thru1", k, 1);
        wait_req("t1_a2", 64'h8000_0008, k);
        check("t1_thru2", k, 1);

        id_ready = 1'b0;
        redir_br(64'h8000_1000);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (req_valid && req_ready) begin
                check("t2_addr", req_addr, 64'h8000_1000 + 64'(4 * n));
                n++;
            end
            tick();
        end
        check("t2_count", n, 4);
        check("t2_stall", req_valid, 0);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_valid && req_ready) begin
                check("t2_pulse_addr", req_addr, 64'h8000_1010);
                n++;
            end
            tick();
        end
        check("t2_pulse_count", n, 1);

        mem_lat = 3;
        id_ready = 1'b1;
        wait_req("t3_pre", 64'h8000_1014, k);
        redir_br(64'h8000_0100);
        check("t3_flush", id_valid, 0);
        check("t3_hold", req_valid, 0);
        mem_lat = 1;
        wait_req("t3_target", 64'h8000_0100, k);

        ex = 1'b1; ex_ret = 1'b1; br_taken = 1'b1;
        ex_entry = 64'h8000_0200; epc = 64'h8000_0300;
        br_target = 64'h8000_0400;
        tick();
        ex = 1'b0; ex_ret = 1'b0; br_taken = 1'b0;
        wait_req("t4_ex", 64'h8000_0200, k);
        ex_ret = 1'b1; br_taken = 1'b1;
        tick();
        ex_ret = 1'b0; br_taken = 1'b0;
        wait_req("t4_eret", 64'h8000_0300, k);

        id_ready = 1'b0;
        mem_lat = 2;
        wait_req("t5_pre", 64'h8000_0304, k);
        wait_rsp("t5_rsp");
        br_taken = 1'b1;
        br_target = 64'h8000_0500;
        id_ready = 1'b1;
        tick();
        br_taken = 1'b0;
        id_ready = 1'b0;
        check("t5_empty", id_valid, 0);
        mem_lat = 1;
        wait_req("t5_target", 64'h8000_0500, k);
        id_ready = 1'b1;

        redir_br(64'h8000_0102);
`ifdef IFU_MISALIGN_CHECK_EN
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_valid) n++;
            tick();
        end
        check("t6_noreq", n, 0);
`else
        wait_req("t6_align", 64'h8000_0100, k);
`endif
        redir_br(64'h8000_0600);
        wait_req("t6_resume", 64'h8000_0600, k);

        redir_br(64'hFFFF_FFFF_FFFF_FFFC);
        wait_req("t7_top", 64'hFFFF_FFFF_FFFF_FFFC, k);
        wait_req("t7_wrap", 64'h0, k);

        mem_lat = 3;
        wait_req("t8_pre", 64'h4, k);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t8_rst_req", req_valid, 0);
        check("t8_rst_id", id_valid, 0);
        mem_lat = 1;
        wait_req("t8_entry", 64'h8000_0000, k);

        repeat (10) tick();
        req_ready = 1'b0;
        repeat (4) tick();
        check("end_req_held", req_valid, 1);
        check("end_id_empty", id_valid, 0);
        check("end_sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Parametrised instruction fetch unit: owns the PC and applies redirects in a fixed priority (exception > exception return > branch). It issues one instruction-memory request at a time over a valid/ready handshake and buffers returned instructions in a small FIFO. The FIFO feeds the decode stage over a valid/ready interface and is flushed on redirect. Sits between the instruction memory port and the IF/ID boundary of the NPC core.

## Interface
Parameters:
- XLEN, 64, PC / address width
- ILEN, 32, instruction width
- PC_ENTRY, 64'h8000_0000, reset PC
- QDEPTH, 4, fetch-queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex  in  1  exception redirect
- ex_entry  in  XLEN  exception vector
- ex_ret  in  1  exception-return redirect
- epc  in  XLEN  return target
- br_taken  in  1  branch redirect
- br_target  in  XLEN  branch target
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_addr  out  XLEN  fetch address
- rsp_valid  in  1  memory response valid (single cycle, always accepted)
- rsp_data  in  ILEN  fetched instruction
- id_valid  out  1  queue head valid
- id_ready  in  1  decode accepts head
- id_pc  out  XLEN  head PC
- id_inst  out  ILEN  head instruction
- id_fault  out  1  head is a misaligned-fetch fault (0 when macro absent)

## Operation
- Redirect = ex | ex_ret | br_taken. Target: ex ? ex_entry : ex_ret ? epc : br_target.
- FSM states:
  - REQ: req_valid=1 when credit available (queue count + 0 outstanding < QDEPTH). On req_valid&req_ready → WAIT, pc_q += 4.
  - WAIT: on rsp_valid, push {pc_req, rsp_data} → REQ.
  - DRAIN: discard the next rsp_valid → REQ.
- Redirect in any state: pc_q ← target; queue flushed (count 0, pointers reset).
  - From REQ: stay in REQ. A handshake in the same cycle counts as outstanding → DRAIN.
  - From WAIT: → DRAIN, unless rsp_valid arrives in the same cycle; that response is dropped → REQ.
  - From DRAIN: stay in DRAIN.
- req_addr = pc_q, held stable while req_valid & !req_ready.
- pc_req register records the address of the outstanding request.
- Queue: head pops on id_valid & id_ready. Push and pop in the same cycle are both legal when full. Credit includes the outstanding request, so overflow is impossible.
- Redirect beats pop: a handshake on the redirect cycle is ignored by the queue, and decode must discard it.
- PC arithmetic is modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: req_valid=0, req_addr=PC_ENTRY, id_valid=0, id_pc=0, id_inst=0, id_fault=0; FSM=REQ; queue empty. Reset mid-transaction drops any in-flight response.
- First request: cycle after rst deasserts, req_addr=PC_ENTRY.
- Latency: response at cycle t gives id_valid=1 at t+1.
- Redirect at t: id_valid=0 at t+1. Request to the target at t+1 if no response is outstanding, otherwise the cycle after the stale response.
- Throughput: at best one instruction per 2 cycles (request + response, no overlap).

## Configuration
- IFU_MISALIGN_CHECK_EN defined: a redirect target with bits[1:0]≠0 issues no memory request. It pushes one entry with id_fault=1, id_pc=target, id_inst=0, then the FSM holds in REQ with req_valid=0 until the next redirect.
- Undefined: target low bits are ignored, target[XLEN-1:2]<<2 is fetched, and id_fault is tied to 0.

## Structure
- Package ifu_pkg: fsm state enum (REQ/WAIT/DRAIN), default PC_ENTRY constant, fetch-entry struct {pc, inst, fault}.
- Sub-module ifu_fetch_queue: synchronous FIFO, parameters DEPTH and entry width; ports push, pop, flush, count, full, empty, head.

## Test plan
- Reset release, req_ready=1, memory returns after 1 cycle → req_addr sequence 8000_0000, 8000_0004, 8000_0008; id_pc matches; id_valid 1 cycle after each rsp_valid.
- id_ready=0 with QDEPTH=4 → exactly 4 requests, then req_valid=0. One id_ready pulse → one new request.
- br_taken=1, br_target=8000_0100 while WAIT → next response discarded; next req_addr=8000_0100; no stale entry at id.
- ex=1, ex_ret=1, br_taken=1 in the same cycle with ex_entry=8000_0200 → next req_addr=8000_0200.
- Redirect coincident with rsp_valid and an id handshake → queue empty next cycle; response not delivered.
- With IFU_MISALIGN_CHECK_EN, br_target=8000_0102 → id_fault=1, id_pc=8000_0102, no req_valid until the next redirect.
